// File: rtl/cache_state_pkg.sv
// ---------------------------------------------------------------------------
// cache_state_pkg
// Shared definitions for the cache state array:
//   - flush walker FSM state encoding (IDLE, FLUSH)
//   - bit positions inside one per-way state element
// Optional feature macro used by the array: CACHE_STATE_ARRAY_PARITY_EN
// ---------------------------------------------------------------------------
package cache_state_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } walker_state_e;

  // Meaning of the low bits of a state element; wider elements keep
  // controller-defined bits above these.
  localparam int VALID_BIT = 0;
  localparam int DIRTY_BIT = 1;

endpackage : cache_state_pkg

// File: rtl/cache_state_flush_walker.sv
// ---------------------------------------------------------------------------
// cache_state_flush_walker
// Walks every set once after reset or on a flush request, emitting one
// clear per cycle. Accesses to the array are blocked while busy.
// Ports:
//   clk_in          clock
//   reset_in        synchronous active-high reset (restarts the walk)
//   flush_req_in    pulse; starts a walk when idle, ignored while walking
//   busy_out        registered; high while the walk is in progress
//   clear_en_out    clear set clear_set_out this cycle
//   clear_set_out   set index being cleared (the walk counter)
// ---------------------------------------------------------------------------
module cache_state_flush_walker
  import cache_state_pkg::*;
#(
  parameter int NUMBER_SETS           = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SETS)
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             flush_req_in,
  output logic                             busy_out,
  output logic                             clear_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0] clear_set_out
);

  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET =
    SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);

  walker_state_e                    r_state;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] r_counter;
  logic                             r_busy;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state   <= FLUSH;
      r_counter <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush_req_in) begin
            r_state   <= FLUSH;
            r_counter <= '0;
            r_busy    <= 1'b1;
          end
        end
        FLUSH: begin
          // Counter wraps to 0 naturally since NUMBER_SETS is a power of two.
          r_counter <= r_counter + SET_PTR_WIDTH_IN_BITS'(1);
          if (r_counter == LAST_SET) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out      = r_busy;
  // No clearing while reset is held: the walk starts on the first edge after release.
  assign clear_en_out  = (r_state == FLUSH) && !reset_in;
  assign clear_set_out = r_counter;

endmodule : cache_state_flush_walker

// File: rtl/cache_state_array.sv
// ---------------------------------------------------------------------------
// cache_state_array
// Per-set, per-way state store for the L1 caches (bit 0 valid, bit 1 dirty).
// Registered one-cycle read, multi-hot way writes, hardware flush walker.
// Optional feature: define CACHE_STATE_ARRAY_PARITY_EN to store one even
// parity bit per way and flag mismatches on reads; otherwise parity_error_out
// is tied low.
// Ports:
//   clk_in, reset_in         clock, synchronous active-high reset
//   access_en_in             access request (dropped while busy_out)
//   access_set_addr_in       target set
//   write_en_in              1 = write, 0 = read
//   write_way_select_in      multi-hot way mask for writes
//   write_element_in         value written into every selected way
//   flush_req_in             pulse: invalidate all sets
//   busy_out                 flush walk in progress
//   read_valid_out           one-cycle pulse, read data valid
//   read_set_state_out       whole set, way w at [w*S +: S]
//   parity_error_out         parity mismatch on the returned set
// ---------------------------------------------------------------------------
module cache_state_array
  import cache_state_pkg::*;
#(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 2,
  parameter int NUMBER_SETS                 = 64,
  parameter int NUMBER_WAYS                 = 16,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic                                                access_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    access_set_addr_in,
  input  logic                                                write_en_in,
  input  logic [NUMBER_WAYS-1:0]                              write_way_select_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]              write_element_in,
  input  logic                                                flush_req_in,
  output logic                                                busy_out,
  output logic                                                read_valid_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0]  read_set_state_out,
  output logic                                                parity_error_out
);

  localparam int S = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int W = NUMBER_WAYS;

  logic                             w_busy;
  logic                             w_clear_en;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] w_clear_set;
  logic                             w_wr_accept;
  logic                             w_rd_accept;
  logic [S*W-1:0]                   w_rd_set;

  cache_state_flush_walker #(
    .NUMBER_SETS          (NUMBER_SETS),
    .SET_PTR_WIDTH_IN_BITS(SET_PTR_WIDTH_IN_BITS)
  ) u_walker (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .flush_req_in (flush_req_in),
    .busy_out     (w_busy),
    .clear_en_out (w_clear_en),
    .clear_set_out(w_clear_set)
  );

  // busy is registered, so an access in the same cycle as flush_req_in is
  // still accepted before the walk begins.
  assign w_wr_accept = access_en_in && !w_busy && !reset_in && write_en_in;
  assign w_rd_accept = access_en_in && !w_busy && !reset_in && !write_en_in;

`ifdef CACHE_STATE_ARRAY_PARITY_EN
  logic [W-1:0] w_par_mismatch;
`endif

  // One storage column per way; the walker and accesses never overlap since
  // accesses are blocked while the walk is busy.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_way
      logic [S-1:0] r_elem_mem [NUMBER_SETS];

      always_ff @(posedge clk_in) begin
        if (w_clear_en) begin
          r_elem_mem[w_clear_set] <= '0;
        end else if (w_wr_accept && write_way_select_in[gi]) begin
          r_elem_mem[access_set_addr_in] <= write_element_in;
        end
      end

      assign w_rd_set[gi*S +: S] = r_elem_mem[access_set_addr_in];

`ifdef CACHE_STATE_ARRAY_PARITY_EN
      logic r_par_mem [NUMBER_SETS];

      always_ff @(posedge clk_in) begin
        if (w_clear_en) begin
          r_par_mem[w_clear_set] <= 1'b0;
        end else if (w_wr_accept && write_way_select_in[gi]) begin
          r_par_mem[access_set_addr_in] <= ^write_element_in;
        end
      end

      // Recompute from the stored element and compare with the stored bit.
      assign w_par_mismatch[gi] = (^w_rd_set[gi*S +: S]) ^ r_par_mem[access_set_addr_in];
`endif
    end
  endgenerate

  logic           r_read_valid;
  logic [S*W-1:0] r_read_data;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_read_valid <= 1'b0;
      r_read_data  <= '0;
    end else begin
      r_read_valid <= w_rd_accept;
      // Data holds its last value between accepted reads.
      if (w_rd_accept) begin
        r_read_data <= w_rd_set;
      end
    end
  end

`ifdef CACHE_STATE_ARRAY_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_rd_accept && (|w_par_mismatch);
    end
  end

  assign parity_error_out = r_parity_err;
`else
  assign parity_error_out = 1'b0;
`endif

  assign busy_out           = w_busy;
  assign read_valid_out     = r_read_valid;
  assign read_set_state_out = r_read_data;

endmodule : cache_state_array

// File: doc/cache_state_array.md
# cache_state_array

Parametrised per-set, per-way state store for the L1 caches, successor to the single-bit valid array. Each way holds a multi-bit state element (bit 0 valid, bit 1 dirty by default). The block adds a registered one-cycle read, multi-hot way writes and a hardware flush walker that clears every set after reset or on request. It sits beside the tag and data arrays and feeds hit/victim logic in the cache controller.

## Interface
- SINGLE_ELEMENT_SIZE_IN_BITS, 2, state bits per way
- NUMBER_SETS, 64, sets; power of two, at least 2
- NUMBER_WAYS, 16, ways per set
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SETS), set index width

- clk_in  in  1  single clock; all state changes on the rising edge
- reset_in  in  1  synchronous, active-high reset
- access_en_in  in  1  access request this cycle
- access_set_addr_in  in  SET_PTR_WIDTH_IN_BITS  target set
- write_en_in  in  1  1 = write, 0 = read (qualified by access_en_in)
- write_way_select_in  in  NUMBER_WAYS  multi-hot mask of ways to write
- write_element_in  in  SINGLE_ELEMENT_SIZE_IN_BITS  value written to every selected way
- flush_req_in  in  1  pulse: invalidate all sets
- busy_out  out  1  flush walk in progress; accesses dropped
- read_valid_out  out  1  read_set_state_out is valid this cycle
- read_set_state_out  out  SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS  way w occupies bits [w*S +: S]
- parity_error_out  out  1  parity mismatch on the returned set; see Configuration

## Operation
- FSM states: IDLE and FLUSH. The flush counter is SET_PTR_WIDTH_IN_BITS wide.
- Reset, including reset asserted mid-walk:
  - state = FLUSH, counter = 0, busy_out = 1.
  - read_valid_out = 0, read_set_state_out = 0, parity_error_out = 0.
- FLUSH:
  - Each cycle with reset_in low, writes all-zero elements to every way of set[counter], then increments the counter.
  - After clearing set NUMBER_SETS-1: counter wraps to 0, state becomes IDLE, busy_out = 0.
- IDLE, access accepted when access_en_in = 1:
  - Write (write_en_in = 1): selected ways of the set take write_element_in; unselected ways are unchanged. An all-zero mask is a no-op.
  - Read (write_en_in = 0): the whole set is registered to read_set_state_out, and read_valid_out pulses.
- flush_req_in in IDLE: enter FLUSH at the next edge. An access in the same cycle is still performed first.
- flush_req_in while busy: ignored; the walk is not restarted.
- access_en_in while busy_out = 1: dropped. No storage change; read_valid_out stays 0.
- read_set_state_out holds its last value until the next accepted read.

## Timing
- Read latency 1:
  - Read accepted at edge N → read_valid_out = 1 and data valid during cycle N+1.
  - read_valid_out is a single-cycle pulse per read.
- Write visible to a read accepted at the following edge (write N, read N+1, data at N+2).
- Write cycles never raise read_valid_out.
- busy_out is high for exactly NUMBER_SETS cycles after reset_in falls, or after the edge that samples flush_req_in.
- Back-to-back reads are sustained at one per cycle.

## Configuration
- Macro: CACHE_STATE_ARRAY_PARITY_EN.
- Defined:
  - One even-parity bit is stored per way, equal to the XOR of the element. The flush clears it to 0.
  - Each read recomputes parity for every way.
  - parity_error_out = 1 alongside read_valid_out if any way mismatches; otherwise 0.
- Undefined:
  - No parity storage.
  - parity_error_out is tied to 0; the port list is unchanged.

## Structure
- Package cache_state_pkg holds:
  - the FSM state enum (IDLE, FLUSH);
  - element bit positions VALID_BIT = 0 and DIRTY_BIT = 1.
- Sub-module cache_state_flush_walker holds the FSM and counter. It outputs busy, the clear-enable and the clear set index.
- Storage is a flop array inside cache_state_array.

## Test plan
Defaults: 64 sets, 16 ways, 2-bit elements.
- Reset held 5 cycles, then released → busy_out = 1 for exactly 64 cycles, then 0. Reads of sets 0..63 all return 0 with read_valid_out = 1 one cycle after each request.
- Write set 5, mask 16'h0009, element 2'b11 → read of set 5 returns bits [1:0] = 11 and [7:6] = 11, all others 0.
- Write set 7 way 15 = 2'b01 at N, read set 7 at N+1 → at N+2, bits [31:30] = 01, read_valid_out = 1. No read_valid_out at N+1.
- Populate sets 0..15, pulse flush_req_in, then write set 3 way 0 while busy → write dropped. After busy_out falls (64 cycles), every set reads 0.
- Assert reset_in when the walk counter is 20 → counter restarts at 0; busy_out stays high a full 64 cycles after release.
- With CACHE_STATE_ARRAY_PARITY_EN defined:
  - Force the stored parity bit of set 9 way 2 to 1, then read set 9 → parity_error_out = 1 in the read_valid_out cycle.
  - Read of an untouched set → parity_error_out = 0.
  - With the macro undefined, the same sequence always gives parity_error_out = 0.
